// File: rtl/counter_16bit_pkg.sv
// counter_16bit_pkg: shared width, count type and reset/max constants
// for the counter_16bit block and its incrementer.
package counter_16bit_pkg;

   localparam int COUNTER_WIDTH = 16;

   typedef logic [COUNTER_WIDTH-1:0] count_t;

   localparam count_t COUNT_RESET = '0;
   localparam count_t COUNT_MAX   = '1;

endpackage

// File: rtl/counter_16bit_if.sv
// counter_16bit_if: enable in, count out (plus tc when
// COUNTER_16BIT_TC_EN is defined). master = user, slave = counter.
interface counter_16bit_if
   import counter_16bit_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) ();

   logic             enable;
   logic [WIDTH-1:0] count;
`ifdef COUNTER_16BIT_TC_EN
   logic             tc;
`endif

   modport master (
      output enable,
`ifdef COUNTER_16BIT_TC_EN
      input  tc,
`endif
      input  count
   );

   modport slave (
      input  enable,
`ifdef COUNTER_16BIT_TC_EN
      output tc,
`endif
      output count
   );

endinterface

// File: rtl/counter_16bit_incr.sv
// counter_16bit_incr: combinational WIDTH-bit +1 with carry-out.
// Ports: a (operand), sum (a+1 mod 2^WIDTH), co (set when a is all-ones).
module counter_16bit_incr
   import counter_16bit_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   assign {co, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/counter_16bit.sv
// counter_16bit: 16-bit synchronous up counter, sync active-high reset,
// count enable. Ports: clk, reset, bus (slave: enable, count, tc).
// Macro COUNTER_16BIT_TC_EN adds the terminal-count output tc.
module counter_16bit
   import counter_16bit_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) (
   input  logic            clk,
   input  logic            reset,
   counter_16bit_if.slave  bus
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_inc;
   logic             co;

   counter_16bit_incr #(
      .WIDTH (WIDTH)
   ) u_incr (
      .a   (cnt),
      .sum (cnt_inc),
      .co  (co)
   );

   // No async reset: state is defined from the first reset edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= WIDTH'(COUNT_RESET);
      end else if (bus.enable) begin
         cnt <= cnt_inc;
      end
   end

   assign bus.count = cnt;

`ifdef COUNTER_16BIT_TC_EN
   // Carry-out is high exactly when cnt is all-ones, so tc flags
   // the cycle whose edge wraps the counter to zero.
   assign bus.tc = co & bus.enable & ~reset;
`else
   logic unused_co;
   assign unused_co = co;
`endif

endmodule

// File: tb/tb_counter_16bit.sv
// tb_counter_16bit: directed stimulus with a queue scoreboard for
// counter_16bit; checks count (and tc when COUNTER_16BIT_TC_EN).
`timescale 1ns/1ps
module tb_counter_16bit;
   import counter_16bit_pkg::*;

   typedef struct {
      bit     chk;
      count_t cnt;
      logic   tc;
   } exp_t;

   logic   clk   = 1'b0;
   logic   reset = 1'b1;
   int     errors = 0;
   int     checks = 0;
   count_t model;
   bit     known = 1'b0;
   exp_t   sb[$];

   counter_16bit_if bus ();

   counter_16bit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #150 clk = ~clk;

   // Inputs change 1 ns after a rising edge. At the following falling
   // edge count still shows the pre-edge state, and tc reflects that
   // state combined with the new inputs.
   task automatic step(input logic r, input logic e);
      exp_t x;
      @(posedge clk);
      #1;
      reset      = r;
      bus.enable = e;
      x.chk = known;
      x.cnt = model;
      x.tc  = known && (model == COUNT_MAX) && e && !r;
      sb.push_back(x);
      if (r) begin
         model = COUNT_RESET;
         known = 1'b1;
      end else if (e) begin
         model = model + 16'd1;
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         if (x.chk) begin
            checks++;
            if (bus.count !== x.cnt) begin
               errors++;
               if (errors <= 20)
                  $display("FAIL count: got %h expected %h at %0t",
                           bus.count, x.cnt, $time);
            end
`ifdef COUNTER_16BIT_TC_EN
            checks++;
            if (bus.tc !== x.tc) begin
               errors++;
               if (errors <= 20)
                  $display("FAIL tc: got %b expected %b at %0t",
                           bus.tc, x.tc, $time);
            end
`endif
         end
      end
   end

   initial begin
      bus.enable = 1'b0;
      // reset hold, with and without enable
      repeat (2) step(1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b1);
      // enable low after reset
      repeat (3) step(1'b0, 1'b0);
      // basic count 1..20
      repeat (20) step(1'b0, 1'b1);
      // pause and resume: 5, hold x4, 6 7 8
      step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1);
      // up to 10, reset with enable high, then 1
      repeat (2) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      // wrap: 65535 increments to 0xFFFF, one more to 0x0000
      step(1'b1, 1'b0);
      repeat (65535) step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/counter_16bit.md
# counter_16bit

Free-running 16-bit synchronous up counter with count enable and synchronous reset. It is a leaf sequential block: it provides a cycle-accurate event or timebase count to surrounding logic. It is also the reference design for post-synthesis, SDF-annotated gate-level regression, so its registered behaviour must be identical before and after synthesis.

## Interface
- `WIDTH`, default 16: counter width in bits. Only 16 is verified.
- `clk` input 1: clock. All state changes on the rising edge.
- `reset` input 1: reset, synchronous, active-high; clock `clk`.
- `enable` input 1: count enable, active-high, sampled on the rising edge of `clk`.
- `count` output `WIDTH` (16): current count value, driven directly from flops. Bit 0 is the LSB. After synthesis, the netlist may expose it as scalar ports `count[0]`..`count[15]`.
- `tc` output 1: terminal count. Present only with `COUNTER_16BIT_TC_EN`.

## Operation
- The state is one `WIDTH`-bit register, `cnt`. The `count` output equals `cnt`. There is no combinational path from inputs to `count`.
- On each rising edge of `clk`, apply the first matching rule:
  - `reset`=1: `cnt` becomes 0, regardless of `enable`.
  - `enable`=1: `cnt` becomes `cnt`+1, modulo 2^WIDTH.
  - Otherwise `cnt` holds.
- Arithmetic is unsigned with no saturation. 0xFFFF + 1 wraps to 0x0000 with no flag, unless the terminal-count feature is enabled.
- Reset has priority over enable when both are asserted on the same edge.
- Power-up value is undefined until the first clock edge with `reset`=1. The flops have no async set or reset.
- There are no other modes and no load input.

## Timing
- Reset value: `count`=0x0000 (and `tc`=0) after the first rising edge with `reset`=1. The value remains 0 while `reset` stays high.
- Latency is one cycle. When `enable`=1 is sampled at edge N, `count` reflects the increment after edge N.
- The first increment after reset release takes effect on the first edge where `reset`=0 and `enable`=1.
- A reset asserted mid-count clears `count` to 0 at that edge. Counting resumes from 0 once `reset` deasserts.
- Dropping `enable` freezes `count` at the edge it is sampled low. Reasserting it continues from the held value with no skip.
- Any number of `enable` toggles is legal. `count` always equals the number of edges with `enable`=1 and `reset`=0 since the last reset edge, modulo 2^16.
- Gate level: `count` must be stable within the clock period. The tested clock period is 300 ns (`clk` toggles every 150 ns).

## Configuration
- Macro: `COUNTER_16BIT_TC_EN`.
- Defined: adds output `tc`.
  - `tc`=1 when `count`==all-ones (0xFFFF) and `enable`=1 and `reset`=0; otherwise `tc`=0.
  - `tc` is combinational from `cnt` and the inputs. It marks the cycle whose edge will wrap the counter to 0.
- Undefined: `tc` port and logic are absent. Counting behaviour is identical in both builds.

## Structure
- Shared package `counter_16bit_pkg`:
  - `COUNTER_WIDTH` = 16
  - `count_t` typedef, `WIDTH` bits unsigned
  - `COUNT_RESET` = 0
  - `COUNT_MAX` = all-ones
- One sub-module, `counter_16bit_incr`: a purely combinational `WIDTH`-bit +1 incrementer with carry-out. The top register stage instantiates it. Its carry-out feeds `tc` when `COUNTER_16BIT_TC_EN` is set.
- The top-level register and priority mux live in `counter_16bit`.

## Test plan
- Reset hold: `reset`=1, `enable`=0 for 2 edges, then `reset`=1 with `enable`=1 -> `count`=0 at every edge.
- Enable low after reset: `reset`=0, `enable`=0 for 3 edges -> `count` stays 0.
- Basic count: `enable`=1 for 20 edges after reset -> `count` = 1, 2, … 20. Each edge's value equals a reference model incremented at that same edge.
- Pause and resume: count to 5, `enable`=0 for 4 edges, `enable`=1 for 3 edges -> `count` holds 5, then reads 6, 7, 8.
- Reset mid-count: at `count`=10, assert `reset` for 1 edge with `enable`=1 -> `count`=0. The next enabled edge gives 1.
- Wrap: run 65535 enabled edges (or 65536 edges total) -> `count`=0xFFFF, and with `COUNTER_16BIT_TC_EN` `tc`=1. The next enabled edge gives `count`=0x0000 and `tc`=0.
